// File: rtl/aha_sif_arbiter.sv
// Two-requester round-robin arbiter for the CGRA SIF bus. One access is granted
// per cycle and forwarded on registered SIF strobes. A read-tag FIFO records
// which requester owns each in-flight read, so in-order read data is routed
// back to the correct requester.
module aha_sif_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    R0_WR_EN,
  input  logic [ADDR_WIDTH-1:0]   R0_WR_ADDR,
  input  logic [DATA_WIDTH-1:0]   R0_WR_DATA,
  input  logic [DATA_WIDTH/8-1:0] R0_WR_STRB,
  input  logic                    R0_RD_EN,
  input  logic [ADDR_WIDTH-1:0]   R0_RD_ADDR,
  output logic                    R0_READY,
  output logic [DATA_WIDTH-1:0]   R0_RD_DATA,
  output logic                    R0_RD_VALID,
  input  logic                    R1_WR_EN,
  input  logic [ADDR_WIDTH-1:0]   R1_WR_ADDR,
  input  logic [DATA_WIDTH-1:0]   R1_WR_DATA,
  input  logic [DATA_WIDTH/8-1:0] R1_WR_STRB,
  input  logic                    R1_RD_EN,
  input  logic [ADDR_WIDTH-1:0]   R1_RD_ADDR,
  output logic                    R1_READY,
  output logic [DATA_WIDTH-1:0]   R1_RD_DATA,
  output logic                    R1_RD_VALID,
  output logic                    SIF_WR_EN,
  output logic [ADDR_WIDTH-1:0]   SIF_WR_ADDR,
  output logic [DATA_WIDTH-1:0]   SIF_WR_DATA,
  output logic [DATA_WIDTH/8-1:0] SIF_WR_STRB,
  output logic                    SIF_RD_EN,
  output logic [ADDR_WIDTH-1:0]   SIF_RD_ADDR,
  input  logic [DATA_WIDTH-1:0]   SIF_RD_DATA,
  input  logic                    SIF_RD_VALID,
  output logic                    RD_ORPHAN
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  // last_grant: 0 = requester 0 won last, 1 = requester 1 won last
  logic             last_grant;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tag_mem [MAX_OUTSTANDING];

  logic full;
  logic empty;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic gnt_any;
  logic gnt_wr;
  logic push;
  logic pop;
  logic head_tag;

  // Request qualification and round-robin grant; fullness uses the pre-pop count
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    req0     = R0_WR_EN | (R0_RD_EN & ~full);
    req1     = R1_WR_EN | (R1_RD_EN & ~full);
    gnt0     = ~RESET & req0 & (~req1 | last_grant);
    gnt1     = ~RESET & req1 & (~req0 | ~last_grant);
    gnt_any  = gnt0 | gnt1;
    gnt_wr   = gnt0 ? R0_WR_EN : R1_WR_EN;
    push     = gnt_any & ~gnt_wr;
    pop      = SIF_RD_VALID & ~empty;
    head_tag = tag_mem[rd_ptr];
  end

  assign R0_READY = gnt0;
  assign R1_READY = gnt1;

  // Grant pointer and registered downstream strobes/payload
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant  <= 1'b1;
      SIF_WR_EN   <= 1'b0;
      SIF_WR_ADDR <= '0;
      SIF_WR_DATA <= '0;
      SIF_WR_STRB <= '0;
      SIF_RD_EN   <= 1'b0;
      SIF_RD_ADDR <= '0;
    end else begin
      if (gnt0) last_grant <= 1'b0;
      else if (gnt1) last_grant <= 1'b1;
      SIF_WR_EN <= gnt_any & gnt_wr;
      SIF_RD_EN <= push;
      if (gnt_any & gnt_wr) begin
        SIF_WR_ADDR <= gnt0 ? R0_WR_ADDR : R1_WR_ADDR;
        SIF_WR_DATA <= gnt0 ? R0_WR_DATA : R1_WR_DATA;
        SIF_WR_STRB <= gnt0 ? R0_WR_STRB : R1_WR_STRB;
      end
      if (push) SIF_RD_ADDR <= gnt0 ? R0_RD_ADDR : R1_RD_ADDR;
    end
  end

  // Tag storage; contents need no reset since occupancy is tracked by count
  always_ff @(posedge CLK) begin
    if (push) tag_mem[wr_ptr] <= gnt1;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)      count <= count + CNT_W'(1);
      else if (~push & pop) count <= count - CNT_W'(1);
    end
  end

  // Read return routing and sticky orphan flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      R0_RD_VALID <= 1'b0;
      R1_RD_VALID <= 1'b0;
      R0_RD_DATA  <= '0;
      R1_RD_DATA  <= '0;
      RD_ORPHAN   <= 1'b0;
    end else begin
      R0_RD_VALID <= pop & ~head_tag;
      R1_RD_VALID <= pop & head_tag;
      if (pop & ~head_tag) R0_RD_DATA <= SIF_RD_DATA;
      if (pop & head_tag)  R1_RD_DATA <= SIF_RD_DATA;
      if (SIF_RD_VALID & empty) RD_ORPHAN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aha_sif_arbiter.sv
// Self-checking bench for aha_sif_arbiter. Inputs change 1ns after the rising
// edge; registered outputs are sampled then, READY 1ns later.
module tb_aha_sif_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        R0_WR_EN, R1_WR_EN, R0_RD_EN, R1_RD_EN;
  logic [31:0] R0_WR_ADDR, R1_WR_ADDR, R0_RD_ADDR, R1_RD_ADDR;
  logic [63:0] R0_WR_DATA, R1_WR_DATA;
  logic [7:0]  R0_WR_STRB, R1_WR_STRB;
  logic        R0_READY, R1_READY, R0_RD_VALID, R1_RD_VALID;
  logic [63:0] R0_RD_DATA, R1_RD_DATA;
  logic        SIF_WR_EN, SIF_RD_EN, SIF_RD_VALID, RD_ORPHAN;
  logic [31:0] SIF_WR_ADDR, SIF_RD_ADDR;
  logic [63:0] SIF_WR_DATA, SIF_RD_DATA;
  logic [7:0]  SIF_WR_STRB;

  aha_sif_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_OUTSTANDING(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .R0_WR_EN(R0_WR_EN), .R0_WR_ADDR(R0_WR_ADDR), .R0_WR_DATA(R0_WR_DATA), .R0_WR_STRB(R0_WR_STRB),
    .R0_RD_EN(R0_RD_EN), .R0_RD_ADDR(R0_RD_ADDR), .R0_READY(R0_READY),
    .R0_RD_DATA(R0_RD_DATA), .R0_RD_VALID(R0_RD_VALID),
    .R1_WR_EN(R1_WR_EN), .R1_WR_ADDR(R1_WR_ADDR), .R1_WR_DATA(R1_WR_DATA), .R1_WR_STRB(R1_WR_STRB),
    .R1_RD_EN(R1_RD_EN), .R1_RD_ADDR(R1_RD_ADDR), .R1_READY(R1_READY),
    .R1_RD_DATA(R1_RD_DATA), .R1_RD_VALID(R1_RD_VALID),
    .SIF_WR_EN(SIF_WR_EN), .SIF_WR_ADDR(SIF_WR_ADDR), .SIF_WR_DATA(SIF_WR_DATA), .SIF_WR_STRB(SIF_WR_STRB),
    .SIF_RD_EN(SIF_RD_EN), .SIF_RD_ADDR(SIF_RD_ADDR),
    .SIF_RD_DATA(SIF_RD_DATA), .SIF_RD_VALID(SIF_RD_VALID), .RD_ORPHAN(RD_ORPHAN)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [31:0] addr; logic [63:0] data; logic [7:0] strb;} wr_t;
  typedef struct {logic tag; logic [63:0] data;} ret_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic        tag_q[$];
  ret_t        ret_q[$];
  logic [63:0] last0, last1;
  wr_t         w;
  ret_t        r;
  logic [31:0] a;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    R0_WR_EN = 0; R1_WR_EN = 0; R0_RD_EN = 0; R1_RD_EN = 0;
    R0_WR_ADDR = '0; R1_WR_ADDR = '0; R0_RD_ADDR = '0; R1_RD_ADDR = '0;
    R0_WR_DATA = '0; R1_WR_DATA = '0; R0_WR_STRB = '0; R1_WR_STRB = '0;
    SIF_RD_VALID = 0; SIF_RD_DATA = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RESET = 1;
    tick(); tick();
    RESET = 0;
    wr_q.delete(); rd_q.delete(); tag_q.delete(); ret_q.delete();
    last0 = '0; last1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1;
    R0_WR_EN = 1; R1_RD_EN = 1;
    tick(); tick();
    checks++; if (SIF_WR_EN !== 1'b0) begin errors++; $display("FAIL rst_sif_wr_en got %b exp 0", SIF_WR_EN); end
    checks++; if (SIF_RD_EN !== 1'b0) begin errors++; $display("FAIL rst_sif_rd_en got %b exp 0", SIF_RD_EN); end
    checks++; if (SIF_WR_ADDR !== 32'h0) begin errors++; $display("FAIL rst_sif_wr_addr got %h exp 0", SIF_WR_ADDR); end
    checks++; if ({R0_RD_VALID, R1_RD_VALID, RD_ORPHAN} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {R0_RD_VALID, R1_RD_VALID, RD_ORPHAN}); end
    checks++; if ({R0_RD_DATA, R1_RD_DATA} !== 128'h0) begin errors++; $display("FAIL rst_rd_data got %h exp 0", {R0_RD_DATA, R1_RD_DATA}); end
    #1;
    checks++; if ({R0_READY, R1_READY} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {R0_READY, R1_READY}); end
    tick();
    apply_reset();
  endtask

  task automatic test_single_write();
    R0_WR_EN = 1; R0_WR_ADDR = 32'h100; R0_WR_DATA = 64'hDEADBEEF_00000001; R0_WR_STRB = 8'hFF;
    wr_q.push_back('{32'h100, 64'hDEADBEEF_00000001, 8'hFF});
    #1;
    checks++; if ({R0_READY, R1_READY} !== 2'b10) begin errors++; $display("FAIL sw_ready got %b exp 10", {R0_READY, R1_READY}); end
    tick();
    R0_WR_EN = 0;
    w = wr_q.pop_front();
    checks++; if (SIF_WR_EN !== 1'b1 || SIF_RD_EN !== 1'b0) begin errors++; $display("FAIL sw_strobes got wr=%b rd=%b exp wr=1 rd=0", SIF_WR_EN, SIF_RD_EN); end
    checks++; if ({SIF_WR_ADDR, SIF_WR_DATA, SIF_WR_STRB} !== {w.addr, w.data, w.strb}) begin errors++; $display("FAIL sw_payload got %h %h %h exp %h %h %h", SIF_WR_ADDR, SIF_WR_DATA, SIF_WR_STRB, w.addr, w.data, w.strb); end
    tick();
    checks++; if (SIF_WR_EN !== 1'b0) begin errors++; $display("FAIL sw_pulse got %b exp 0", SIF_WR_EN); end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      R0_WR_EN = 1; R1_WR_EN = 1;
      R0_WR_ADDR = 32'h200 + 32'(i); R1_WR_ADDR = 32'h300 + 32'(i);
      R0_WR_DATA = 64'hA000 + 64'(i); R1_WR_DATA = 64'hB000 + 64'(i);
      R0_WR_STRB = 8'h0F; R1_WR_STRB = 8'hF0;
      if (i % 2 == 0) wr_q.push_back('{32'h200 + 32'(i), 64'hA000 + 64'(i), 8'h0F});
      else            wr_q.push_back('{32'h300 + 32'(i), 64'hB000 + 64'(i), 8'hF0});
      #1;
      checks++; if ({R0_READY, R1_READY} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ready[%0d] got %b", i, {R0_READY, R1_READY}); end
      tick();
      w = wr_q.pop_front();
      checks++; if (SIF_WR_EN !== 1'b1 || {SIF_WR_ADDR, SIF_WR_DATA, SIF_WR_STRB} !== {w.addr, w.data, w.strb}) begin errors++; $display("FAIL rr_sif[%0d] got en=%b %h %h exp %h %h", i, SIF_WR_EN, SIF_WR_ADDR, SIF_WR_DATA, w.addr, w.data); end
    end
    idle_inputs();
  endtask

  task automatic test_read_limit();
    int n = 0;
    logic prev = 0;
    R1_RD_EN = 1;
    for (int i = 0; i < 6; i++) begin
      R1_RD_ADDR = 32'h40 + 32'(n * 8);
      #1;
      checks++; if (R1_READY !== (n < 4) || R0_READY !== 1'b0) begin errors++; $display("FAIL lim_ready[%0d] got %b exp %b", i, R1_READY, (n < 4)); end
      prev = (n < 4);
      if (prev) begin rd_q.push_back(32'h40 + 32'(n * 8)); tag_q.push_back(1'b1); n++; end
      tick();
      checks++; if (SIF_RD_EN !== prev) begin errors++; $display("FAIL lim_sif_rd_en[%0d] got %b exp %b", i, SIF_RD_EN, prev); end
      if (prev) begin
        a = rd_q.pop_front();
        checks++; if (SIF_RD_ADDR !== a) begin errors++; $display("FAIL lim_sif_rd_addr[%0d] got %h exp %h", i, SIF_RD_ADDR, a); end
      end
    end
    // Pop in this cycle: still blocked because fullness is judged pre-pop
    R1_RD_ADDR = 32'h60;
    SIF_RD_VALID = 1; SIF_RD_DATA = 64'h1111_0000;
    ret_q.push_back('{tag_q.pop_front(), 64'h1111_0000});
    #1;
    checks++; if (R1_READY !== 1'b0) begin errors++; $display("FAIL lim_block_on_pop got %b exp 0", R1_READY); end
    tick();
    SIF_RD_VALID = 0;
    r = ret_q.pop_front();
    checks++; if (R1_RD_VALID !== r.tag || R0_RD_VALID !== ~r.tag || R1_RD_DATA !== r.data) begin errors++; $display("FAIL lim_ret0 got v1=%b v0=%b d=%h exp d=%h", R1_RD_VALID, R0_RD_VALID, R1_RD_DATA, r.data); end
    last1 = r.data;
    #1;
    checks++; if (R1_READY !== 1'b1) begin errors++; $display("FAIL lim_fifth_ready got %b exp 1", R1_READY); end
    rd_q.push_back(32'h60); tag_q.push_back(1'b1);
    tick();
    R1_RD_EN = 0;
    a = rd_q.pop_front();
    checks++; if (SIF_RD_EN !== 1'b1 || SIF_RD_ADDR !== a) begin errors++; $display("FAIL lim_fifth_sif got en=%b %h exp %h", SIF_RD_EN, SIF_RD_ADDR, a); end
    for (int j = 0; j < 4; j++) begin
      SIF_RD_VALID = 1; SIF_RD_DATA = 64'h2222_0000 + 64'(j);
      ret_q.push_back('{tag_q.pop_front(), 64'h2222_0000 + 64'(j)});
      tick();
      r = ret_q.pop_front();
      checks++; if (R1_RD_VALID !== 1'b1 || R0_RD_VALID !== 1'b0 || R1_RD_DATA !== r.data || R0_RD_DATA !== last0) begin errors++; $display("FAIL lim_drain[%0d] got v0=%b v1=%b d=%h exp d=%h", j, R0_RD_VALID, R1_RD_VALID, R1_RD_DATA, r.data); end
      last1 = r.data;
    end
    SIF_RD_VALID = 0;
    tick();
    checks++; if ({R0_RD_VALID, R1_RD_VALID, RD_ORPHAN} !== 3'b000) begin errors++; $display("FAIL lim_quiet got %b exp 000", {R0_RD_VALID, R1_RD_VALID, RD_ORPHAN}); end
  endtask

  task automatic test_interleave();
    logic        own [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] adr [3] = '{32'h10, 32'h20, 32'h30};
    logic [63:0] dat [3] = '{64'hAAAA_AAAA_0000_000A, 64'hBBBB_BBBB_0000_000B, 64'hCCCC_CCCC_0000_000C};
    for (int k = 0; k < 3; k++) begin
      if (own[k]) begin R1_RD_EN = 1; R1_RD_ADDR = adr[k]; end
      else        begin R0_RD_EN = 1; R0_RD_ADDR = adr[k]; end
      rd_q.push_back(adr[k]); tag_q.push_back(own[k]);
      #1;
      checks++; if ({R0_READY, R1_READY} !== (own[k] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL il_ready[%0d] got %b", k, {R0_READY, R1_READY}); end
      tick();
      R0_RD_EN = 0; R1_RD_EN = 0;
      a = rd_q.pop_front();
      checks++; if (SIF_RD_EN !== 1'b1 || SIF_RD_ADDR !== a) begin errors++; $display("FAIL il_sif[%0d] got en=%b %h exp %h", k, SIF_RD_EN, SIF_RD_ADDR, a); end
    end
    for (int k = 0; k < 3; k++) begin
      SIF_RD_VALID = 1; SIF_RD_DATA = dat[k];
      ret_q.push_back('{tag_q.pop_front(), dat[k]});
      tick();
      r = ret_q.pop_front();
      if (r.tag) begin
        checks++; if (R1_RD_VALID !== 1'b1 || R0_RD_VALID !== 1'b0 || R1_RD_DATA !== r.data || R0_RD_DATA !== last0) begin errors++; $display("FAIL il_ret[%0d] got v0=%b v1=%b d0=%h d1=%h exp d1=%h", k, R0_RD_VALID, R1_RD_VALID, R0_RD_DATA, R1_RD_DATA, r.data); end
        last1 = r.data;
      end else begin
        checks++; if (R0_RD_VALID !== 1'b1 || R1_RD_VALID !== 1'b0 || R0_RD_DATA !== r.data || R1_RD_DATA !== last1) begin errors++; $display("FAIL il_ret[%0d] got v0=%b v1=%b d0=%h d1=%h exp d0=%h", k, R0_RD_VALID, R1_RD_VALID, R0_RD_DATA, R1_RD_DATA, r.data); end
        last0 = r.data;
      end
    end
    SIF_RD_VALID = 0;
    tick();
  endtask

  task automatic test_wr_then_rd();
    R0_WR_EN = 1; R0_RD_EN = 1;
    R0_WR_ADDR = 32'h500; R0_WR_DATA = 64'h5555; R0_WR_STRB = 8'h3C; R0_RD_ADDR = 32'h600;
    wr_q.push_back('{32'h500, 64'h5555, 8'h3C});
    #1;
    checks++; if ({R0_READY, R1_READY} !== 2'b10) begin errors++; $display("FAIL wr_rd_ready_t got %b exp 10", {R0_READY, R1_READY}); end
    tick();
    R0_WR_EN = 0;
    w = wr_q.pop_front();
    checks++; if (SIF_WR_EN !== 1'b1 || SIF_RD_EN !== 1'b0 || SIF_WR_ADDR !== w.addr || SIF_WR_STRB !== w.strb) begin errors++; $display("FAIL wr_rd_t1 got wr=%b rd=%b %h exp %h", SIF_WR_EN, SIF_RD_EN, SIF_WR_ADDR, w.addr); end
    rd_q.push_back(32'h600); tag_q.push_back(1'b0);
    #1;
    checks++; if (R0_READY !== 1'b1) begin errors++; $display("FAIL wr_rd_ready_t1 got %b exp 1", R0_READY); end
    tick();
    R0_RD_EN = 0;
    a = rd_q.pop_front();
    checks++; if (SIF_RD_EN !== 1'b1 || SIF_WR_EN !== 1'b0 || SIF_RD_ADDR !== a) begin errors++; $display("FAIL wr_rd_t2 got wr=%b rd=%b %h exp %h", SIF_WR_EN, SIF_RD_EN, SIF_RD_ADDR, a); end
    SIF_RD_VALID = 1; SIF_RD_DATA = 64'h6666_6666;
    ret_q.push_back('{tag_q.pop_front(), 64'h6666_6666});
    tick();
    SIF_RD_VALID = 0;
    r = ret_q.pop_front();
    checks++; if (R0_RD_VALID !== ~r.tag || R1_RD_VALID !== r.tag || R0_RD_DATA !== r.data) begin errors++; $display("FAIL wr_rd_ret got v0=%b d=%h exp d=%h", R0_RD_VALID, R0_RD_DATA, r.data); end
    last0 = r.data;
    tick();
  endtask

  task automatic test_orphan();
    checks++; if (RD_ORPHAN !== 1'b0) begin errors++; $display("FAIL orph_pre got %b exp 0", RD_ORPHAN); end
    SIF_RD_VALID = 1; SIF_RD_DATA = 64'h0BAD;
    tick();
    SIF_RD_VALID = 0;
    checks++; if ({RD_ORPHAN, R0_RD_VALID, R1_RD_VALID} !== 3'b100) begin errors++; $display("FAIL orph_set got %b exp 100", {RD_ORPHAN, R0_RD_VALID, R1_RD_VALID}); end
    checks++; if (R0_RD_DATA !== last0 || R1_RD_DATA !== last1) begin errors++; $display("FAIL orph_data_hold got %h %h exp %h %h", R0_RD_DATA, R1_RD_DATA, last0, last1); end
    tick(); tick();
    checks++; if (RD_ORPHAN !== 1'b1) begin errors++; $display("FAIL orph_sticky got %b exp 1", RD_ORPHAN); end
    R0_RD_EN = 1; R0_RD_ADDR = 32'h50;
    tick();
    R0_RD_EN = 0; R1_RD_EN = 1; R1_RD_ADDR = 32'h60;
    tick();
    R1_RD_EN = 0;
    checks++; if (SIF_RD_EN !== 1'b1 || SIF_RD_ADDR !== 32'h60) begin errors++; $display("FAIL orph_reads got en=%b %h exp 60", SIF_RD_EN, SIF_RD_ADDR); end
    RESET = 1;
    tick();
    RESET = 0;
    checks++; if ({RD_ORPHAN, SIF_RD_EN, SIF_WR_EN} !== 3'b000) begin errors++; $display("FAIL orph_reset got %b exp 000", {RD_ORPHAN, SIF_RD_EN, SIF_WR_EN}); end
    SIF_RD_VALID = 1; SIF_RD_DATA = 64'h1234;
    tick();
    SIF_RD_VALID = 0;
    checks++; if ({RD_ORPHAN, R0_RD_VALID, R1_RD_VALID} !== 3'b100) begin errors++; $display("FAIL orph_after_reset got %b exp 100", {RD_ORPHAN, R0_RD_VALID, R1_RD_VALID}); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    last0 = '0; last1 = '0;
    RESET = 1;
    idle_inputs();
    tick();
    test_reset();
    test_single_write();
    test_contention();
    test_read_limit();
    test_interleave();
    test_wr_then_rd();
    test_orphan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
